// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: arbitrates the CPU and loader ports onto a 1-cycle
// synchronous word RAM; handles sub-word loads, RMW stores, misalignment.
// Ports: CLK/RST (async, active high); c_* CPU load/store port;
// l_* loader word port; mem_* RAM side (registered address/data/we).
module data_mem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [2:0]        c_funct3,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_ack,
  output logic              c_err,
  output logic [31:0]       c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_ack,
  output logic [31:0]       l_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_MERGE  = 2'd3;

  logic [1:0]  state;
  logic        last_l;
  logic        cur_l;
  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [1:0]  cur_off;
  logic [31:0] cur_wdata;

  logic        grant_c;
  logic        grant_l;
  logic        c_bad;
  logic        sel_we;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] ld_val;
  logic [31:0] merged;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  logic unused_bits;
  assign unused_bits = ^{c_addr[31:ADDR_W+2],
                         l_addr[31:ADDR_W+2],
                         l_addr[1:0]};

  // Tie goes to whoever did not win last time.
  assign grant_c = c_req & (~l_req | last_l);
  assign grant_l = l_req & ~grant_c;

  always_comb begin
    c_bad = 1'b0;
    unique case (c_funct3)
      3'b011, 3'b110, 3'b111: c_bad = 1'b1;
      3'b001, 3'b101:         c_bad = c_addr[0];
      3'b010:                 c_bad = |c_addr[1:0];
      default:                c_bad = 1'b0;
    endcase
  end

  assign sel_we    = grant_l ? l_we    : c_we;
  assign sel_f3    = grant_l ? 3'b010  : c_funct3;
  assign sel_addr  = grant_l ? l_addr  : c_addr;
  assign sel_wdata = grant_l ? l_wdata : c_wdata;

  assign bsh    = {cur_off, 3'b000};
  assign hsh    = {cur_off[1], 4'b0000};
  assign byte_v = 8'(mem_rdata >> bsh);
  assign half_v = cur_off[1] ? mem_rdata[31:16]
                             : mem_rdata[15:0];

  always_comb begin
    ld_val = mem_rdata;
    unique case (cur_f3)
      3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_val = {{16{half_v[15]}}, half_v};
      3'b100:  ld_val = {24'd0, byte_v};
      3'b101:  ld_val = {16'd0, half_v};
      default: ld_val = mem_rdata;
    endcase
  end

  // funct3[0] selects half vs byte for SB/SH.
  always_comb begin
    lane_mask = 32'h0000_00FF << bsh;
    lane_data = {24'd0, cur_wdata[7:0]} << bsh;
    if (cur_f3[0]) begin
      lane_mask = 32'h0000_FFFF << hsh;
      lane_data = {16'd0, cur_wdata[15:0]} << hsh;
    end
    merged = (mem_rdata & ~lane_mask)
           | (lane_data & lane_mask);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      last_l    <= 1'b1;
      cur_l     <= 1'b0;
      cur_we    <= 1'b0;
      cur_f3    <= 3'd0;
      cur_off   <= 2'd0;
      cur_wdata <= 32'd0;
      c_ack     <= 1'b0;
      c_err     <= 1'b0;
      c_rdata   <= 32'd0;
      l_ack     <= 1'b0;
      l_rdata   <= 32'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      mem_we    <= 1'b0;
    end else begin
      c_ack  <= 1'b0;
      c_err  <= 1'b0;
      l_ack  <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Skip the ack cycle so the requester can drop req.
          if (!(c_ack || l_ack) && (c_req || l_req)) begin
            last_l <= grant_l;
            cur_l  <= grant_l;
            if (grant_c && c_bad) begin
              c_ack <= 1'b1;
              c_err <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              cur_we    <= sel_we;
              cur_f3    <= sel_f3;
              cur_off   <= sel_addr[1:0];
              cur_wdata <= sel_wdata;
              mem_addr  <= sel_addr[ADDR_W+1:2];
              if (sel_we && sel_f3 == 3'b010) begin
                mem_we    <= 1'b1;
                mem_wdata <= sel_wdata;
              end
            end
          end
        end
        S_ISSUE: begin
          if (cur_we && cur_f3 == 3'b010) begin
            state <= S_IDLE;
            if (cur_l) l_ack <= 1'b1;
            else       c_ack <= 1'b1;
          end else begin
            state <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          if (!cur_we) begin
            state <= S_IDLE;
            if (cur_l) begin
              l_ack   <= 1'b1;
              l_rdata <= mem_rdata;
            end else begin
              c_ack   <= 1'b1;
              c_rdata <= ld_val;
            end
          end else begin
            state     <= S_MERGE;
            mem_wdata <= merged;
            mem_we    <= 1'b1;
          end
        end
        S_MERGE: begin
          state <= S_IDLE;
          if (cur_l) l_ack <= 1'b1;
          else       c_ack <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl with a
// behavioural 1-cycle RAM; expected results queued at issue time.
module tb_data_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        c_req = 1'b0;
  logic        c_we = 1'b0;
  logic [2:0]  c_funct3 = 3'd0;
  logic [31:0] c_addr = 32'd0;
  logic [31:0] c_wdata = 32'd0;
  logic        c_ack;
  logic        c_err;
  logic [31:0] c_rdata;
  logic        l_req = 1'b0;
  logic        l_we = 1'b0;
  logic [31:0] l_addr = 32'd0;
  logic [31:0] l_wdata = 32'd0;
  logic        l_ack;
  logic [31:0] l_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;

  typedef struct {
    logic        src;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        chk;
    logic        err;
    int          lat;
  } op_t;

  op_t sbq[$];

  data_mem_ctrl #(.ADDR_W(10)) dut (
    .CLK(CLK), .RST(RST),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3),
    .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_ack(l_ack), .l_rdata(l_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  logic [31:0] ram [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
  end
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end
  always @(posedge CLK) if (mem_we) we_cnt++;

  task automatic xfer(input op_t o, output int lat,
                      output logic [31:0] rd,
                      output logic er,
                      output logic [9:0] ma);
    @(negedge CLK);
    if (!o.src) begin
      c_req = 1'b1; c_we = o.we; c_funct3 = o.f3;
      c_addr = o.addr; c_wdata = o.wd;
    end else begin
      l_req = 1'b1; l_we = o.we;
      l_addr = o.addr; l_wdata = o.wd;
    end
    lat = 0; rd = '0; er = 1'b0; ma = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (n == 1) ma = mem_addr;
      if (o.src ? l_ack : c_ack) begin
        lat = n;
        rd  = o.src ? l_rdata : c_rdata;
        er  = o.src ? 1'b0 : c_err;
        break;
      end
    end
    c_req = 1'b0;
    l_req = 1'b0;
  endtask

  task automatic run_table(input string tag, input op_t t[$]);
    int lat; logic [31:0] rd; logic er; logic [9:0] ma;
    op_t e;
    foreach (t[i]) begin
      sbq.push_back(t[i]);
      xfer(t[i], lat, rd, er, ma);
      e = sbq.pop_front();
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL %s[%0d] latency got %0d want %0d",
                 tag, i, lat, e.lat);
      end
      checks++;
      if (er !== e.err) begin
        errors++;
        $display("FAIL %s[%0d] err got %0b want %0b",
                 tag, i, er, e.err);
      end
      if (e.chk) begin
        checks++;
        if (rd !== e.exp) begin
          errors++;
          $display("FAIL %s[%0d] rdata got %h want %h",
                   tag, i, rd, e.exp);
        end
      end
      if (!e.err) begin
        checks++;
        if (ma !== e.addr[11:2]) begin
          errors++;
          $display("FAIL %s[%0d] mem_addr got %h want %h",
                   tag, i, ma, e.addr[11:2]);
        end
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({c_ack, c_err, l_ack, mem_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {c_ack, c_err, l_ack, mem_we});
    end
    checks++;
    if ({c_rdata, l_rdata, mem_wdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h want 0",
               c_rdata, l_rdata, mem_wdata);
    end
    checks++;
    if (mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0", mem_addr);
    end
    RST = 1'b0;
  endtask

  task automatic test_sw_lw();
    op_t t[$];
    t.push_back('{0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0, 2});
    t.push_back('{0, 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 1, 0, 3});
    run_table("sw_lw", t);
  endtask

  task automatic test_ext();
    op_t t[$];
    t.push_back('{0, 1, 3'b010, 32'h20, 32'h80FF7F01, 0, 0, 0, 2});
    t.push_back('{0, 0, 3'b000, 32'h23, 0, 32'hFFFFFF80, 1, 0, 3});
    t.push_back('{0, 0, 3'b100, 32'h23, 0, 32'h00000080, 1, 0, 3});
    t.push_back('{0, 0, 3'b001, 32'h22, 0, 32'hFFFF80FF, 1, 0, 3});
    t.push_back('{0, 0, 3'b101, 32'h20, 0, 32'h00007F01, 1, 0, 3});
    t.push_back('{0, 0, 3'b000, 32'h21, 0, 32'h0000007F, 1, 0, 3});
    t.push_back('{0, 0, 3'b001, 32'h20, 0, 32'h00007F01, 1, 0, 3});
    run_table("ext", t);
  endtask

  task automatic test_rmw();
    op_t t[$];
    t.push_back('{1, 1, 3'b010, 32'h30, 32'h11223344, 0, 0, 0, 2});
    t.push_back('{0, 1, 3'b000, 32'h31, 32'h000000AA, 0, 0, 0, 4});
    t.push_back('{0, 0, 3'b010, 32'h30, 0, 32'h1122AA44, 1, 0, 3});
    t.push_back('{0, 1, 3'b001, 32'h32, 32'h0000BEEF, 0, 0, 0, 4});
    t.push_back('{0, 0, 3'b010, 32'h30, 0, 32'hBEEFAA44, 1, 0, 3});
    t.push_back('{1, 0, 3'b010, 32'h1033, 0, 32'hBEEFAA44, 1, 0, 3});
    t.push_back('{0, 0, 3'b010, 32'hF030, 0, 32'hBEEFAA44, 1, 0, 3});
    run_table("rmw", t);
  endtask

  task automatic test_errors();
    op_t t[$];
    int w0;
    w0 = we_cnt;
    t.push_back('{0, 0, 3'b010, 32'h41, 0, 0, 0, 1, 1});
    t.push_back('{0, 1, 3'b001, 32'h43, 32'h1234, 0, 0, 1, 1});
    t.push_back('{0, 0, 3'b011, 32'h40, 0, 0, 0, 1, 1});
    t.push_back('{0, 0, 3'b101, 32'h45, 0, 0, 0, 1, 1});
    t.push_back('{0, 1, 3'b010, 32'h42, 32'h5555, 0, 0, 1, 1});
    run_table("err", t);
    checks++;
    if (we_cnt !== w0) begin
      errors++;
      $display("FAIL err_mem_we got %0d writes want 0",
               we_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    op_t q[$];
    op_t e;
    int n_ack = 0;
    logic prev = 1'b0;
    logic cur;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = '{(i % 2) == 1, 0, 3'b010, 0, 0, 0, 1, 0, 0};
      e.exp = e.src ? 32'hBEEFAA44 : 32'hDEADBEEF;
      q.push_back(e);
    end
    @(negedge CLK);
    c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010;
    c_addr = 32'h10;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h30;
    for (int n = 0; n < 40 && n_ack < 4; n++) begin
      @(negedge CLK);
      cur = c_ack | l_ack;
      if (c_ack && l_ack) begin
        checks++; errors++;
        $display("FAIL rr_both_ack got 11 want one");
      end
      if (cur) begin
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL rr_pulse ack high two cycles");
        end
        e = q.pop_front();
        checks++;
        if (l_ack !== e.src) begin
          errors++;
          $display("FAIL rr_order[%0d] got l=%0b want l=%0b",
                   n_ack, l_ack, e.src);
        end
        checks++;
        if ((l_ack ? l_rdata : c_rdata) !== e.exp) begin
          errors++;
          $display("FAIL rr_data[%0d] got %h want %h", n_ack,
                   l_ack ? l_rdata : c_rdata, e.exp);
        end
        n_ack++;
      end
      prev = cur;
    end
    c_req = 1'b0;
    l_req = 1'b0;
    checks++;
    if (n_ack != 4) begin
      errors++;
      $display("FAIL rr_timeout got %0d acks want 4", n_ack);
    end
  endtask

  task automatic test_reset_mid();
    op_t t[$];
    op_t s;
    logic seen_we = 1'b0;
    t.push_back('{1, 1, 3'b010, 32'h50, 32'h12345678, 0, 0, 0, 2});
    run_table("rst_pre", t);
    @(negedge CLK);
    c_req = 1'b1; c_we = 1'b1; c_funct3 = 3'b000;
    c_addr = 32'h50; c_wdata = 32'hAB;
    for (int n = 1; n <= 3; n++) begin
      @(negedge CLK);
      if (n == 3) seen_we = mem_we;
    end
    checks++;
    if (seen_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_merge mem_we got %b want 1", seen_we);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({c_ack, c_err, l_ack, mem_we, mem_addr,
         mem_wdata, c_rdata, l_rdata} !== '0) begin
      errors++;
      $display("FAIL rst_async outs got we=%b a=%h wd=%h cr=%h",
               mem_we, mem_addr, mem_wdata, c_rdata);
    end
    c_req = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    s = '{0, 0, 3'b010, 32'h50, 0, 32'h12345678, 1, 0, 3};
    t.delete();
    t.push_back(s);
    run_table("rst_post", t);
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_ext();
    test_rmw();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
